// File: rtl/signed_alu_sched.sv
// Round-robin scheduler sharing one signed add/sub/mul/compare unit among NUM_REQ requesters.
// One operation in flight at a time; tagged result returned over a valid/ready handshake.
module signed_alu_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [3*NUM_REQ-1:0]       req_op,
  input  logic [WIDTH*NUM_REQ-1:0]   req_a,
  input  logic [WIDTH*NUM_REQ-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [2*WIDTH-1:0]         rsp_data,
  output logic                       rsp_ovf,
  output logic                       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL2 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_LT  = 3'd3;
  localparam logic [2:0] OP_GT  = 3'd4;
  localparam logic [2:0] OP_LE  = 3'd5;
  localparam logic [2:0] OP_GE  = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  localparam int LO_W = WIDTH / 2;

  logic [1:0]                state_reg;
  logic [ID_W-1:0]           last_reg;
  logic [ID_W-1:0]           id_reg;
  logic [2:0]                op_reg;
  logic signed [WIDTH-1:0]   a_reg;
  logic signed [WIDTH-1:0]   b_reg;
  logic signed [2*WIDTH-1:0] mul_lo_reg;
  logic signed [2*WIDTH-1:0] mul_hi_reg;
  logic [2*WIDTH-1:0]        data_reg;
  logic                      ovf_reg;

  logic [2:0]       op_arr   [NUM_REQ];
  logic [WIDTH-1:0] a_arr    [NUM_REQ];
  logic [WIDTH-1:0] b_arr    [NUM_REQ];
  logic [ID_W-1:0]  scan_idx [NUM_REQ];
  logic             hit      [NUM_REQ];
  logic             found_chain [NUM_REQ+1];
  logic [ID_W-1:0]  id_chain    [NUM_REQ+1];

  logic            grant_found;
  logic [ID_W-1:0] grant_id;

  assign found_chain[0] = 1'b0;
  assign id_chain[0]    = '0;

  // scan_idx[k] is the k-th candidate after the last grant, wrapping around
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign op_arr[gi]   = req_op[3*gi +: 3];
      assign a_arr[gi]    = req_a[WIDTH*gi +: WIDTH];
      assign b_arr[gi]    = req_b[WIDTH*gi +: WIDTH];
      assign scan_idx[gi] = ID_W'((int'(last_reg) + gi + 1) % NUM_REQ);
      assign hit[gi]      = req_valid[scan_idx[gi]] && !found_chain[gi];
      assign found_chain[gi+1] = found_chain[gi] | req_valid[scan_idx[gi]];
      assign id_chain[gi+1]    = id_chain[gi] | (hit[gi] ? scan_idx[gi] : '0);
      assign req_ready[gi] = (state_reg == S_IDLE) && grant_found && (grant_id == ID_W'(gi));
    end
  endgenerate

  assign grant_found = found_chain[NUM_REQ];
  assign grant_id    = id_chain[NUM_REQ];

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;

  assign sum     = a_reg + b_reg;
  assign diff    = a_reg - b_reg;
  assign add_ovf = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
  assign sub_ovf = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff[WIDTH-1] != a_reg[WIDTH-1]);

  // Product split on b: a*b = (a*b_hi << LO_W) + a*b_lo, halves summed in MUL2
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_lo_ext;
  logic signed [2*WIDTH-1:0] b_hi_ext;
  logic signed [2*WIDTH-1:0] p_lo;
  logic signed [2*WIDTH-1:0] p_hi;

  assign a_ext    = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
  assign b_lo_ext = {{(2*WIDTH-LO_W){1'b0}}, b_reg[LO_W-1:0]};
  assign b_hi_ext = {{(WIDTH+LO_W){b_reg[WIDTH-1]}}, b_reg[WIDTH-1:LO_W]};
  assign p_lo     = a_ext * b_lo_ext;
  assign p_hi     = a_ext * b_hi_ext;

  logic [2*WIDTH-1:0] alu_data;
  logic               alu_ovf;

  always_comb begin
    alu_data = '0;
    alu_ovf  = 1'b0;
    case (op_reg)
      OP_ADD: begin
        alu_data = {{WIDTH{sum[WIDTH-1]}}, sum};
        alu_ovf  = add_ovf;
      end
      OP_SUB: begin
        alu_data = {{WIDTH{diff[WIDTH-1]}}, diff};
        alu_ovf  = sub_ovf;
      end
      OP_LT:   alu_data[0] = (a_reg <  b_reg);
      OP_GT:   alu_data[0] = (a_reg >  b_reg);
      OP_LE:   alu_data[0] = (a_reg <= b_reg);
      OP_GE:   alu_data[0] = (a_reg >= b_reg);
      OP_EQ:   alu_data[0] = (a_reg == b_reg);
      default: alu_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      last_reg   <= ID_W'(NUM_REQ - 1);
      id_reg     <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      mul_lo_reg <= '0;
      mul_hi_reg <= '0;
      data_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_found) begin
            op_reg    <= op_arr[grant_id];
            a_reg     <= a_arr[grant_id];
            b_reg     <= b_arr[grant_id];
            id_reg    <= grant_id;
            last_reg  <= grant_id;
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_reg == OP_MUL) begin
            mul_lo_reg <= p_lo;
            mul_hi_reg <= p_hi;
            state_reg  <= S_MUL2;
          end else begin
            data_reg  <= alu_data;
            ovf_reg   <= alu_ovf;
            state_reg <= S_RESP;
          end
        end
        S_MUL2: begin
          data_reg  <= (mul_hi_reg << LO_W) + mul_lo_reg;
          ovf_reg   <= 1'b0;
          state_reg <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_reg == S_RESP);
  assign busy      = (state_reg != S_IDLE);
  assign rsp_id    = id_reg;
  assign rsp_data  = data_reg;
  assign rsp_ovf   = ovf_reg;

endmodule

// File: doc/signed_alu_sched.md
# signed_alu_sched

Round-robin scheduler that shares one signed arithmetic unit among `NUM_REQ` requesters. The unit supports add, sub, multiply and the signed compares. The block sits between client blocks that issue signed two's-complement operations and a single shared add/sub/mul/compare datapath. It arbitrates, captures operands, sequences single-cycle and two-cycle operations, and returns one tagged response at a time over a valid/ready handshake.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `WIDTH`, 8: operand width, signed two's complement.
- `ID_W`, $clog2(`NUM_REQ`): width of the requester tag.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester operation valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept. At most one bit high.
- `req_op`  in  3*`NUM_REQ`  opcode, packed with requester i at [3i+2:3i].
- `req_a`  in  `WIDTH`*`NUM_REQ`  signed operand a, packed.
- `req_b`  in  `WIDTH`*`NUM_REQ`  signed operand b, packed.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  `ID_W`  index of the requester that issued the operation.
- `rsp_data`  out  2*`WIDTH`  signed result.
- `rsp_ovf`  out  1  signed overflow of an add/sub result.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 LT, 100 GT, 101 LE, 110 GE, 111 EQ.
- ADD/SUB:
  - The result is `WIDTH` bits, wrapping modulo 2^`WIDTH`, then sign-extended into `rsp_data`.
  - `rsp_ovf` = 1 when both operands have the same sign (ADD), or differing signs (SUB), and the result sign differs from a.
- MUL: full signed product, 2*`WIDTH` bits, never truncated. `rsp_ovf` = 0.
- Compares:
  - Fully signed, so −1 < 1.
  - The result is 0 or 1 in bit 0, zero-extended. `rsp_ovf` = 0.
- FSM states: IDLE, EXEC, MUL2, RESP.
  - IDLE: if any `req_valid` is high, grant g = the first valid index scanning from `last`+1 with wrap-around. Drive `req_ready[g]`=1 combinationally. On that edge capture op, a, b and g, set `last`=g, and go to EXEC. `req_ready` is 0 in every other state.
  - EXEC: ADD, SUB and compares register their result and go to RESP. MUL registers the first pipeline stage and goes to MUL2.
  - MUL2: register the final product and go to RESP.
  - RESP: `rsp_valid`=1. `rsp_id`, `rsp_data` and `rsp_ovf` stay stable until `rsp_valid`&&`rsp_ready`. On that handshake go to IDLE and drop `rsp_valid` next cycle.
- One operation is in flight at a time. No new grant is issued while the block is busy.
- Requesters must hold `req_valid`, op and operands stable until their `req_ready`. Dropping `req_valid` before the grant withdraws the request, with no side effect.
- `last` updates only on a grant. An idle requester never blocks the others. With all requesters continuously valid, service order is cyclic.

## Timing
- Reset values: state IDLE, `last`=`NUM_REQ`−1 (requester 0 wins first), `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_ovf`=0, `busy`=0, `req_ready`=0.
- Let the accept edge be T.
- Latency for ADD, SUB and compares: `rsp_valid` is high in cycle T+2 (IDLE→EXEC→RESP).
- Latency for MUL: `rsp_valid` is high in cycle T+3.
- The earliest next grant is the cycle after the response handshake. Peak throughput is one non-MUL op per 3 cycles and one MUL per 4 cycles with `rsp_ready` tied high.
- Reset mid-operation, in any state: the in-flight op is discarded without a response, and the block returns to reset values on the next edge.
- Reset wins over a simultaneous grant or handshake.
- If `rsp_ready` is already high when RESP is entered, the handshake completes in that first RESP cycle.

## Test plan
1. Req0 ADD, a=100, b=50 (`WIDTH`=8) → at T+2: `rsp_data`=16'hFF96 (−106), `rsp_ovf`=1, `rsp_id`=0.
2. Req2 MUL, a=−128, b=−128 → at T+3: `rsp_data`=16'h4000 (16384), `rsp_ovf`=0, `rsp_id`=2. Also MUL 127×−128 → 16'hC080.
3. Compares: LT(−1,1)=1, GT(−1,1)=0, LE(5,5)=1, GE(−128,127)=0, EQ(−128,−128)=1. Also SUB(−128,1): `rsp_data`=16'h007F, `rsp_ovf`=1.
4. All 4 requesters held valid with `rsp_ready`=1 → grant order 0,1,2,3,0,1; each `req_ready` one-hot, with exactly one pulse per grant.
5. `rsp_ready` held low for 5 cycles in RESP → `rsp_valid`/`rsp_data`/`rsp_id` stable, `busy`=1, no `req_ready` asserted. The response is accepted on the 6th cycle and the next grant follows one cycle later.
6. `rst` asserted during MUL2 → next cycle `rsp_valid`=0, `busy`=0, no response for that op. With requesters 1 and 3 then valid, requester 1 is granted first.
